// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Build option: SERIAL_SUB_OVF_EN enables the signed-overflow flag.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; else ovf = 0.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q;
   logic [WIDTH-1:0] sa_q, sb_q;
   logic [WIDTH-2:0] dsr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, busy_q, done_q;
   logic             bit_d, bout_d, last;

   full_subtractor u_fs (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .bin  (br_q),
      .diff (bit_d),
      .bout (bout_d)
   );

   // Full result = new bit on top of the W-1 bits already shifted in.
   assign diff_d = {bit_d, dsr_q};
   assign cnt_d  = cnt_q + CW'(1);
   assign last   = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         dsr_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  br_q    <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               br_q  <= bout_d;
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               dsr_q <= diff_d[WIDTH-1:1];
               if (last) begin
                  diff_q   <= diff_d;
                  borrow_q <= bout_d;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic am_q, bm_q, ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         am_q  <= 1'b0;
         bm_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         am_q <= a[WIDTH-1];
         bm_q <= b[WIDTH-1];
      end else if (state_q == RUN && last) begin
         ovf_q <= (am_q != bm_q) && (bit_d != am_q);
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases plus random ops.
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, borrow, ovf;
   logic [W-1:0] diff;

   exp_t sbq[$];
   exp_t held = '{d: '0, br: 1'b0, ov: 1'b0};
   logic prev_done = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int   sd;
      e.d  = W'((int'(av) - int'(bv)) & ((1 << W) - 1));
      e.br = (int'(av) < int'(bv));
      sd   = int'($signed(av)) - int'($signed(bv));
`ifdef SERIAL_SUB_OVF_EN
      e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
`else
      e.ov = 1'b0;
      if (sd == 0) e.ov = 1'b0;
`endif
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         check("done_single_cycle", {31'b0, prev_done}, 0);
         if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sbq.pop_front();
            check("diff", {24'b0, diff}, {24'b0, e.d});
            check("borrow", {31'b0, borrow}, {31'b0, e.br});
            check("ovf", {31'b0, ovf}, {31'b0, e.ov});
            held = e;
         end
      end
      prev_done = done;
   end

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int ign_k, input int rst_k);
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      sbq.push_back(model(av, bv));
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         check("busy_in_run", {31'b0, busy}, 1);
         check("no_early_done", {31'b0, done}, 0);
         check("hold_diff", {24'b0, diff}, {24'b0, held.d});
         check("hold_borrow", {31'b0, borrow}, {31'b0, held.br});
         if (k == rst_k) begin
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check("abort_busy", {31'b0, busy}, 0);
            check("abort_done", {31'b0, done}, 0);
            check("abort_diff", {24'b0, diff}, 0);
            check("abort_borrow", {31'b0, borrow}, 0);
            check("abort_ovf", {31'b0, ovf}, 0);
            void'(sbq.pop_back());
            held = '{d: '0, br: 1'b0, ov: 1'b0};
            return;
         end
         start = (k == ign_k);
         if (k == ign_k) begin
            a = 8'd1;
            b = 8'd1;
         end
      end
      start = 1'b0;
      @(negedge clk);
      check("done_latency", {31'b0, done}, 1);
      check("busy_in_done", {31'b0, busy}, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_diff", {24'b0, diff}, 0);
      check("rst_borrow", {31'b0, borrow}, 0);
      check("rst_ovf", {31'b0, ovf}, 0);
      rst = 1'b0;

      run_op(8'd100, 8'd37, -1, -1);
      run_op(8'd5, 8'd9, -1, -1);
      run_op(8'h80, 8'h01, -1, -1);
      run_op(8'hAA, 8'hAA, -1, -1);
      run_op(8'h00, 8'hFF, -1, -1);
      run_op(8'd50, 8'd20, 2, -1);
      run_op(8'd33, 8'd11, -1, 3);
      run_op(8'd7, 8'd3, -1, -1);
      run_op(8'h7F, 8'h80, -1, -1);
      run_op(8'hFF, 8'h00, -1, -1);

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 10 == 3) rb = ra;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(ra, rb, (i % 7 == 0) ? int'($urandom_range(0, W - 2)) : -1, -1);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
